// File: rtl/wbs_mem_bridge.sv
// Wishbone slave: 32-bit beats to NUM_CH wide SRAM channels plus ctrl/status regs.
// Ports: wb_clk_i/wb_rst_i, wbs_* bus slave, wbs_mode/wbs_debug, mem_* SRAM side.
module wbs_mem_bridge #(
  parameter int          NUM_CH    = 4,
  parameter int          CH_WIDTH  = 64,
  parameter int          ADDR_W    = 6,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_dat_i,
  input  logic [31:0]                wbs_adr_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  output logic                       wbs_mode,
  output logic                       wbs_debug,
  output logic [NUM_CH-1:0]          mem_csb0,
  output logic [NUM_CH-1:0]          mem_web0,
  output logic [ADDR_W-1:0]          mem_addr0,
  output logic [CH_WIDTH-1:0]        mem_wdata0,
  input  logic [NUM_CH*CH_WIDTH-1:0] mem_rdata0
);

  localparam int BEATS  = (CH_WIDTH + 31) / 32;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PAD_W  = BEATS * 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_t;

  state_t state_q, state_d;

  logic                ack_q;
  logic [31:0]         dat_q;
  logic                mode_q;
  logic                debug_q;
  logic [NUM_CH-1:0]   csb_q;
  logic [NUM_CH-1:0]   web_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CH_WIDTH-1:0] wdata_q;
  logic [PAD_W-1:0]    stg_q;
  logic [BEATS-1:0]    mask_q;
  logic [7:0]          err_q;
  logic [PAD_W-1:0]    buf_q;
  logic                buf_v_q;
  logic [3:0]          buf_ch_q;
  logic [ADDR_W-1:0]   buf_word_q;
  logic [3:0]          cur_ch_q;
  logic [ADDR_W-1:0]   cur_word_q;
  logic [BEAT_W-1:0]   cur_beat_q;
  logic [1:0]          cnt_q, cnt_d;

  logic [3:0]          region;
  logic                base_hit;
  logic [BEAT_W-1:0]   beat;
  logic [ADDR_W-1:0]   word;
  logic [3:0]          ch;
  logic                req;
  logic                is_reg;
  logic                is_ch;
  logic                is_err;
  logic                hit;
  logic                last_beat;
  logic [3:0]          mask4;
  logic [31:0]         reg_rd;
  logic [PAD_W-1:0]    stg_m;
  logic [CH_WIDTH-1:0] rword;
  logic [PAD_W-1:0]    rpad;

  logic                ack_d;
  logic                dat_ld;
  logic [31:0]         dat_d;
  logic                err_inc;
  logic                reg_wr;
  logic                stg_wr;
  logic                commit;
  logic                issue;
  logic                buf_ld;

  assign region    = wbs_adr_i[27:24];
  assign base_hit  = wbs_adr_i[31:28] == BASE_ADDR[31:28];
  assign beat      = wbs_adr_i[BEAT_W-1:0];
  assign word      = wbs_adr_i[BEAT_W +: ADDR_W];
  assign ch        = region - 4'd1;
  assign req       = (state_q == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign is_reg    = base_hit && (region == 4'd0);
  assign is_ch     = base_hit && (region != 4'd0) &&
                     (int'(region) <= NUM_CH) &&
                     (int'(beat) < BEATS) && debug_q;
  assign is_err    = !is_reg && !is_ch;
  assign hit       = buf_v_q && (buf_ch_q == ch) &&
                     (buf_word_q == word);
  assign last_beat = int'(beat) == (BEATS - 1);
  assign mask4     = 4'(mask_q);

  // Beat lanes of the staging word; unselected bytes keep staged data.
  always_comb begin
    stg_m = stg_q;
    for (int b = 0; b < 4; b++) begin
      if (wbs_sel_i[b]) begin
        stg_m[int'(beat)*32 + b*8 +: 8] = wbs_dat_i[b*8 +: 8];
      end
    end
  end

  // Zero-pad the fetched word so a narrow top beat reads zero-extended.
  always_comb begin
    rword = mem_rdata0[int'(cur_ch_q)*CH_WIDTH +: CH_WIDTH];
    rpad  = '0;
    rpad[CH_WIDTH-1:0] = rword;
  end

  always_comb begin
    reg_rd = '0;
    unique case (wbs_adr_i[3:0])
      4'd0:    reg_rd = {30'd0, debug_q, mode_q};
      4'd1:    reg_rd = {19'd0, buf_v_q, mask4, err_q};
      4'd2:    reg_rd = {24'd0, err_q};
      default: reg_rd = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    dat_ld  = 1'b0;
    dat_d   = '0;
    err_inc = 1'b0;
    reg_wr  = 1'b0;
    stg_wr  = 1'b0;
    commit  = 1'b0;
    issue   = 1'b0;
    buf_ld  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACK;
          ack_d   = 1'b1;
          dat_ld  = 1'b1;
          if (is_err) begin
            err_inc = 1'b1;
          end else if (is_reg) begin
            if (wbs_we_i) reg_wr = 1'b1;
            else dat_d = reg_rd;
          end else if (wbs_we_i) begin
            stg_wr = 1'b1;
            commit = last_beat;
          end else if (hit) begin
            dat_d = buf_q[int'(beat)*32 +: 32];
          end else begin
            state_d = ISSUE;
            ack_d   = 1'b0;
            dat_ld  = 1'b0;
            issue   = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = 2'd0;
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == 2'(RD_LAT - 1)) begin
          state_d = ACK;
          ack_d   = 1'b1;
          dat_ld  = 1'b1;
          dat_d   = rpad[int'(cur_beat_q)*32 +: 32];
          buf_ld  = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      mode_q     <= 1'b0;
      debug_q    <= 1'b0;
      csb_q      <= '1;
      web_q      <= '1;
      addr_q     <= '0;
      wdata_q    <= '0;
      stg_q      <= '0;
      mask_q     <= '0;
      err_q      <= '0;
      buf_q      <= '0;
      buf_v_q    <= 1'b0;
      buf_ch_q   <= '0;
      buf_word_q <= '0;
      cur_ch_q   <= '0;
      cur_word_q <= '0;
      cur_beat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      csb_q   <= '1;
      web_q   <= '1;
      if (dat_ld) dat_q <= dat_d;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
      if (reg_wr) begin
        if (wbs_adr_i[3:0] == 4'd0) begin
          mode_q  <= wbs_dat_i[0];
          debug_q <= wbs_dat_i[1];
          buf_v_q <= 1'b0;
        end
        if (wbs_adr_i[3:0] == 4'd2) err_q <= '0;
      end
      if (stg_wr) begin
        stg_q        <= stg_m;
        mask_q[beat] <= 1'b1;
      end
      // Commit on the last beat; staging data survives for later merges.
      if (commit) begin
        csb_q   <= ~(NUM_CH'(1) << ch);
        web_q   <= ~(NUM_CH'(1) << ch);
        addr_q  <= word;
        wdata_q <= stg_m[CH_WIDTH-1:0];
        mask_q  <= '0;
        if (hit) buf_v_q <= 1'b0;
      end
      if (issue) begin
        csb_q      <= ~(NUM_CH'(1) << ch);
        addr_q     <= word;
        cur_ch_q   <= ch;
        cur_word_q <= word;
        cur_beat_q <= beat;
      end
      if (buf_ld) begin
        buf_q      <= rpad;
        buf_v_q    <= 1'b1;
        buf_ch_q   <= cur_ch_q;
        buf_word_q <= cur_word_q;
      end
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign wbs_mode   = mode_q;
  assign wbs_debug  = debug_q;
  assign mem_csb0   = csb_q;
  assign mem_web0   = web_q;
  assign mem_addr0  = addr_q;
  assign mem_wdata0 = wdata_q;

  logic unused_adr;
  assign unused_adr = ^wbs_adr_i[23:4];

endmodule
